sc_game_flow_fsm: RTL and testbench
===================================

# sc_game_flow_fsm

Parametrised game-flow supervisor for the Frogger datapath. It generalises the general state machine: it owns the lives and level counters internally instead of relying on external comparators. It converts collision, goal and start events into life loss, level advance, optional bonus life, timed board-clear holds and terminal win/lose states. It sits between the playfield/collision logic and the score/lives display.

## Interface
- MAX_LIVES, 7 — lives ceiling (bonus life never exceeds it)
- START_LIVES, 3 — lives loaded on reset and on new game; 1..MAX_LIVES
- NUM_LEVELS, 5 — last level; level counts 1..NUM_LEVELS
- HOLD_CYCLES, 25000000 — board-clear freeze length after hit/goal (0.5 s at 50 MHz); >=1
- LIVES_W, $clog2(MAX_LIVES+1) — lives bus width
- LEVEL_W, $clog2(NUM_LEVELS+1) — level bus width

Ports:
- SC_STATEMACHINEGENERAL_CLOCK_50  in  1  system clock
- SC_STATEMACHINEGENERAL_RESET_InHigh  in  1  reset, asynchronous, active-high
- startButton_InLow  in  1  asynchronous push button, active-low
- collision_InLow  in  1  frog hit/drowned, synchronous level, active-low
- goal_InLow  in  1  frog reached last row, synchronous level, active-low
- lives_Out  out  LIVES_W  current lives
- level_Out  out  LEVEL_W  current level
- playing_OutHigh  out  1  game running
- clearBoard_OutLow  out  1  playfield reset/freeze request
- gameOver_OutHigh  out  1  lost
- gameWon_OutHigh  out  1  won

## Operation
- Events:
  - startButton_InLow passes through a 2-flop synchroniser and then a falling-edge detector.
  - collision_InLow and goal_InLow each use a falling-edge detector only (one prev-sample flop, reset to 1).
  - A held-low input produces exactly one event.
- States:
  - IDLE: counters at START_LIVES/1.
    - Start event -> PLAY.
  - PLAY:
    - Collision event -> HIT.
    - Else goal event -> GOAL.
    - Simultaneous events: collision wins and the goal is discarded.
  - HIT:
    - lives==1 -> GAME_OVER, lives<=0.
    - Else -> HOLD, lives<=lives-1.
  - GOAL:
    - level==NUM_LEVELS -> WIN, level unchanged.
    - Else -> HOLD, level<=level+1, plus bonus life (see Configuration).
  - HOLD: counter loads HOLD_CYCLES-1 on entry and decrements.
    - At 0 -> PLAY.
    - Events during HOLD are ignored; edge-detector flops keep tracking.
  - GAME_OVER / WIN: latched.
    - Start event -> IDLE, reloading lives=START_LIVES, level=1.
    - A further start event is needed to play.
- Outputs (Moore, decoded from the state register):
  - playing_OutHigh=1 only in PLAY.
  - clearBoard_OutLow=0 in IDLE and HOLD.
  - gameOver_OutHigh=1 in GAME_OVER.
  - gameWon_OutHigh=1 in WIN.
- Arithmetic:
  - Lives saturate at MAX_LIVES and never underflow.
  - Level never exceeds NUM_LEVELS.
- Illegal state encodings -> IDLE next cycle.

## Timing
- Reset: state IDLE, lives_Out=START_LIVES, level_Out=1, playing 0, clearBoard 0, gameOver 0, gameWon 0, hold counter 0, edge flops 1.
- Reset mid-operation (any state, including HOLD) returns to the above immediately and asynchronously.
- Collision/goal latency:
  - The first low sample at edge N makes the state HIT/GOAL after edge N.
  - Counters update at edge N+1.
  - playing_OutHigh drops after edge N.
- Start latency: 3 clock edges from the synchronised low to the state change.
- HOLD lasts exactly HOLD_CYCLES cycles; PLAY resumes on the next edge.

## Configuration
- SC_GAMEFLOW_BONUS_LIFE_EN defined:
  - GOAL->HOLD also does lives<=lives+1 when lives<MAX_LIVES.
  - At MAX_LIVES the bonus is dropped.
- Undefined: lives change only on HIT, and MAX_LIVES acts only as a width bound.

## Structure
- Shared package sc_game_pkg:
  - state enum (IDLE, PLAY, HIT, GOAL, HOLD, GAME_OVER, WIN) with fixed 3-bit encoding
  - default constants for lives, levels and HOLD_CYCLES
- Sub-module sc_edge_event: optional 2-flop synchroniser plus falling-edge pulse, parameter SYNC_EN. Instantiated three times (start with SYNC_EN=1).
- FSM, hold counter and lives/level registers stay in the top module.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Reset, then start press -> state PLAY 3 cycles after release of reset-sync; lives=3, level=1, clearBoard high.
- Three collision pulses, each after HOLD ends:
  - lives go 3->2->1.
  - clearBoard low exactly 4 cycles each time.
  - Third hit -> lives 0, gameOver=1, playing=0.
- Five goals with BONUS_LIFE_EN, lives=3, MAX_LIVES=7:
  - level 1..5, lives 3->7.
  - Fifth goal -> gameWon=1, level stays 5.
  - Repeat with MAX_LIVES=4: lives saturate at 4.
- Collision and goal low on the same cycle -> HIT only, level unchanged; collision held low 20 cycles -> single decrement.
- Reset asserted during HOLD -> IDLE immediately, lives=3, level=1, clearBoard low.
- In GAME_OVER, start press -> IDLE with counters reloaded; second press -> PLAY.

Source files
------------

// File: rtl/sc_game_pkg.sv
// Shared types and defaults for the Frogger game-flow supervisor.
// Holds the fixed 3-bit state encoding so the FSM and any debug logic agree on it.
package sc_game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    HIT       = 3'd2,
    GOAL      = 3'd3,
    HOLD      = 3'd4,
    GAME_OVER = 3'd5,
    WIN       = 3'd6
  } gameState_e;

  localparam int DEFAULT_MAX_LIVES   = 7;
  localparam int DEFAULT_START_LIVES = 3;
  localparam int DEFAULT_NUM_LEVELS  = 5;
  localparam int DEFAULT_HOLD_CYCLES = 25000000;

  // Width of a down-counter that must hold values 0..count-1, never narrower than one bit.
  function automatic int counterWidth(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/sc_edge_event.sv
// Turns an active-low level into a single-cycle event pulse on its falling edge.
// SYNC_EN adds a 2-flop synchroniser for inputs that come straight from a pin.
// The pulse is combinational from the sampled level, so a synchronous input is
// acted on at the same edge that first sees it low.
module sc_edge_event #(
  parameter bit SYNC_EN = 1'b0
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic signalLow_i,
  output logic event_o
);

  logic sampledLow;
  logic prevLow_q;

  generate
    if (SYNC_EN) begin : gSync
      logic syncStage1_q;
      logic syncStage2_q;

      // Two-stage synchroniser; idles high so reset never looks like a press.
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          syncStage1_q <= 1'b1;
          syncStage2_q <= 1'b1;
        end else begin
          syncStage1_q <= signalLow_i;
          syncStage2_q <= syncStage1_q;
        end
      end

      assign sampledLow = syncStage2_q;
    end else begin : gNoSync
      assign sampledLow = signalLow_i;
    end
  endgenerate

  // Previous sample keeps tracking at all times so a held-low input fires only once.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      prevLow_q <= 1'b1;
    end else begin
      prevLow_q <= sampledLow;
    end
  end

  assign event_o = prevLow_q & ~sampledLow;

endmodule

// File: rtl/sc_game_flow_fsm.sv
// Game-flow supervisor for the Frogger datapath: owns lives and level, turns
// collision/goal/start events into life loss, level advance, board-clear holds
// and the latched win/lose states.
// Optional feature macro: SC_GAMEFLOW_BONUS_LIFE_EN (bonus life on each cleared level).
module sc_game_flow_fsm
  import sc_game_pkg::*;
#(
  parameter int MAX_LIVES   = DEFAULT_MAX_LIVES,
  parameter int START_LIVES = DEFAULT_START_LIVES,
  parameter int NUM_LEVELS  = DEFAULT_NUM_LEVELS,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int LIVES_W     = $clog2(MAX_LIVES + 1),
  parameter int LEVEL_W     = $clog2(NUM_LEVELS + 1)
) (
  input  logic               SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic               SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic               startButton_InLow,
  input  logic               collision_InLow,
  input  logic               goal_InLow,
  output logic [LIVES_W-1:0] lives_Out,
  output logic [LEVEL_W-1:0] level_Out,
  output logic               playing_OutHigh,
  output logic               clearBoard_OutLow,
  output logic               gameOver_OutHigh,
  output logic               gameWon_OutHigh
);

  localparam int HOLD_W = counterWidth(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_FIRST = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(NUM_LEVELS);

  gameState_e         state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [HOLD_W-1:0]  holdCount_q, holdCount_d;

  logic startEvent;
  logic collisionEvent;
  logic goalEvent;

  sc_edge_event #(.SYNC_EN(1'b1)) uStartEdge (
    .clock_i     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .reset_i     (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .signalLow_i (startButton_InLow),
    .event_o     (startEvent)
  );

  sc_edge_event #(.SYNC_EN(1'b0)) uCollisionEdge (
    .clock_i     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .reset_i     (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .signalLow_i (collision_InLow),
    .event_o     (collisionEvent)
  );

  sc_edge_event #(.SYNC_EN(1'b0)) uGoalEdge (
    .clock_i     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .reset_i     (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .signalLow_i (goal_InLow),
    .event_o     (goalEvent)
  );

  // State, counters and hold timer; reset drops everything back to a fresh game at once.
  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      state_q     <= IDLE;
      lives_q     <= LIVES_START;
      level_q     <= LEVEL_FIRST;
      holdCount_q <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      holdCount_q <= holdCount_d;
    end
  end

  // Next-state and counter updates; HIT/GOAL are one-cycle bookkeeping states before HOLD.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    holdCount_d = holdCount_q;

    case (state_q)
      IDLE: begin
        lives_d = LIVES_START;
        level_d = LEVEL_FIRST;
        if (startEvent) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (collisionEvent) begin
          state_d = HIT;
        end else if (goalEvent) begin
          state_d = GOAL;
        end
      end

      HIT: begin
        if (lives_q <= LIVES_W'(1)) begin
          state_d = GAME_OVER;
          lives_d = '0;
        end else begin
          state_d     = HOLD;
          lives_d     = lives_q - LIVES_W'(1);
          holdCount_d = HOLD_LOAD;
        end
      end

      GOAL: begin
        if (level_q >= LEVEL_LAST) begin
          state_d = WIN;
        end else begin
          state_d     = HOLD;
          level_d     = level_q + LEVEL_W'(1);
          holdCount_d = HOLD_LOAD;
`ifdef SC_GAMEFLOW_BONUS_LIFE_EN
          if (lives_q < LIVES_W'(MAX_LIVES)) begin
            lives_d = lives_q + LIVES_W'(1);
          end
`else
          lives_d = lives_q;
`endif
        end
      end

      HOLD: begin
        if (holdCount_q == '0) begin
          state_d = PLAY;
        end else begin
          holdCount_d = holdCount_q - HOLD_W'(1);
        end
      end

      GAME_OVER, WIN: begin
        if (startEvent) begin
          state_d = IDLE;
          lives_d = LIVES_START;
          level_d = LEVEL_FIRST;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign lives_Out         = lives_q;
  assign level_Out         = level_q;
  assign playing_OutHigh   = (state_q == PLAY);
  assign clearBoard_OutLow = ~((state_q == IDLE) || (state_q == HOLD));
  assign gameOver_OutHigh  = (state_q == GAME_OVER);
  assign gameWon_OutHigh   = (state_q == WIN);

endmodule

// File: tb/tb_sc_game_flow_fsm.sv
// Directed testbench for sc_game_flow_fsm with HOLD_CYCLES=4.
// A second instance with MAX_LIVES=4 shares the stimulus to show bonus-life saturation.
// Expected lives on level advance follow SC_GAMEFLOW_BONUS_LIFE_EN.
module tb_sc_game_flow_fsm;

`ifdef SC_GAMEFLOW_BONUS_LIFE_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       startButton;
  logic       collision;
  logic       goal;

  logic [2:0] lives;
  logic [2:0] level;
  logic       playing;
  logic       clearBoard;
  logic       gameOver;
  logic       gameWon;

  logic [2:0] lives4;
  logic [2:0] level4;
  logic       playing4;
  logic       clearBoard4;
  logic       gameOver4;
  logic       gameWon4;

  int checks = 0;
  int errors = 0;

  sc_game_flow_fsm #(
    .MAX_LIVES   (7),
    .START_LIVES (3),
    .NUM_LEVELS  (5),
    .HOLD_CYCLES (4)
  ) dut (
    .SC_STATEMACHINEGENERAL_CLOCK_50     (clock),
    .SC_STATEMACHINEGENERAL_RESET_InHigh (reset),
    .startButton_InLow                   (startButton),
    .collision_InLow                     (collision),
    .goal_InLow                          (goal),
    .lives_Out                           (lives),
    .level_Out                           (level),
    .playing_OutHigh                     (playing),
    .clearBoard_OutLow                   (clearBoard),
    .gameOver_OutHigh                    (gameOver),
    .gameWon_OutHigh                     (gameWon)
  );

  sc_game_flow_fsm #(
    .MAX_LIVES   (4),
    .START_LIVES (3),
    .NUM_LEVELS  (5),
    .HOLD_CYCLES (4)
  ) dut4 (
    .SC_STATEMACHINEGENERAL_CLOCK_50     (clock),
    .SC_STATEMACHINEGENERAL_RESET_InHigh (reset),
    .startButton_InLow                   (startButton),
    .collision_InLow                     (collision),
    .goal_InLow                          (goal),
    .lives_Out                           (lives4),
    .level_Out                           (level4),
    .playing_OutHigh                     (playing4),
    .clearBoard_OutLow                   (clearBoard4),
    .gameOver_OutHigh                    (gameOver4),
    .gameWon_OutHigh                     (gameWon4)
  );

  // Free-running clock, rising edge active.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Press start, confirm nothing moves before the third edge, check the result, then release.
  task automatic applyStimulus(input logic preClear, input logic expPlaying, input logic expClear,
                               input int expLives, input int expLevel);
    startButton = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("start_not_early", clearBoard, preClear);
    @(negedge clock);
    checkOutput("start_playing", playing, expPlaying);
    checkOutput("start_clear", clearBoard, expClear);
    checkOutput("start_lives", lives, expLives);
    checkOutput("start_level", level, expLevel);
    startButton = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Count board-clear cycles from the first HOLD cycle until play resumes.
  task automatic waitHoldEnd();
    int lowCycles;
    lowCycles = 0;
    while (clearBoard === 1'b0 && lowCycles < 20) begin
      lowCycles++;
      @(negedge clock);
    end
    checkOutput("hold_length", lowCycles, 4);
    checkOutput("resume_playing", playing, 1);
  endtask

  task automatic applyHit(input int expLives, input bit expOver);
    collision = 1'b0;
    @(negedge clock);
    checkOutput("hit_playing_drop", playing, 0);
    checkOutput("hit_lives_not_yet", lives, expLives + 1);
    collision = 1'b1;
    @(negedge clock);
    checkOutput("hit_lives", lives, expLives);
    if (expOver) begin
      checkOutput("over_flag", gameOver, 1);
      checkOutput("over_playing", playing, 0);
      checkOutput("over_clear", clearBoard, 1);
    end else begin
      checkOutput("hit_clear_low", clearBoard, 0);
      waitHoldEnd();
    end
  endtask

  initial begin
    int exp7;
    int exp4;

    reset       = 1'b1;
    startButton = 1'b1;
    collision   = 1'b1;
    goal        = 1'b1;
    repeat (2) @(negedge clock);

    checkOutput("rst_lives", lives, 3);
    checkOutput("rst_level", level, 1);
    checkOutput("rst_playing", playing, 0);
    checkOutput("rst_clear", clearBoard, 0);
    checkOutput("rst_over", gameOver, 0);
    checkOutput("rst_won", gameWon, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    applyStimulus(1'b0, 1'b1, 1'b1, 3, 1);

    applyHit(2, 1'b0);
    applyHit(1, 1'b0);
    applyHit(0, 1'b1);

    repeat (3) @(negedge clock);
    checkOutput("over_latched", gameOver, 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 3, 1);
    checkOutput("idle_over_cleared", gameOver, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3, 1);

    collision = 1'b0;
    goal      = 1'b0;
    @(negedge clock);
    checkOutput("both_playing_drop", playing, 0);
    repeat (19) @(negedge clock);
    checkOutput("both_lives", lives, 2);
    checkOutput("both_level", level, 1);
    checkOutput("both_playing", playing, 1);
    collision = 1'b1;
    goal      = 1'b1;
    repeat (2) @(negedge clock);

    goal = 1'b0;
    @(negedge clock);
    goal = 1'b1;
    @(negedge clock);
    checkOutput("pre_rst_level", level, 2);
    checkOutput("pre_rst_clear", clearBoard, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_lives", lives, 3);
    checkOutput("async_rst_level", level, 1);
    checkOutput("async_rst_clear", clearBoard, 0);
    checkOutput("async_rst_playing", playing, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    applyStimulus(1'b0, 1'b1, 1'b1, 3, 1);

    for (int g = 1; g <= 4; g++) begin
      exp7 = BONUS_EN ? 3 + g : 3;
      exp4 = BONUS_EN ? ((3 + g > 4) ? 4 : 3 + g) : 3;
      goal = 1'b0;
      @(negedge clock);
      checkOutput("goal_playing_drop", playing, 0);
      goal = 1'b1;
      @(negedge clock);
      checkOutput("goal_level", level, g + 1);
      checkOutput("goal_lives", lives, exp7);
      checkOutput("goal_lives_max4", lives4, exp4);
      waitHoldEnd();
    end

    exp7 = BONUS_EN ? 7 : 3;
    exp4 = BONUS_EN ? 4 : 3;
    goal = 1'b0;
    @(negedge clock);
    goal = 1'b1;
    @(negedge clock);
    checkOutput("win_flag", gameWon, 1);
    checkOutput("win_flag_max4", gameWon4, 1);
    checkOutput("win_level", level, 5);
    checkOutput("win_playing", playing, 0);
    checkOutput("win_lives", lives, exp7);
    checkOutput("win_lives_max4", lives4, exp4);

    goal = 1'b0;
    @(negedge clock);
    goal = 1'b1;
    @(negedge clock);
    checkOutput("win_goal_ignored", level, 5);
    checkOutput("win_latched", gameWon, 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 3, 1);
    checkOutput("idle_won_cleared", gameWon, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
